// File: rtl/seven_segment_capture.sv
// -----------------------------------------------------------------------------
// seven_segment_capture
//
// Receive-side monitor for a multiplexed 4-digit seven-segment bus. It samples
// the anode/segment lines and decodes each active digit's segment pattern back
// to a hex nibble. Once all four digits have been seen, it publishes one
// coherent 4-digit word. It also flags malformed anode or segment patterns
// and a stalled scan.
//
// Ports
//   clk_100MHz   in   1   system clock
//   reset        in   1   asynchronous, active-low reset
//   anode        in   4   digit enables, active-low, one-hot-low when valid
//   segment      in   7   segment drives, active-low, bit0=a .. bit6=g
//   digits       out 16   captured frame, [3:0]=digit 0 .. [15:12]=digit 3
//   blank_mask   out  4   1 = digit was blank (7'h7F) in the frame
//   frame_valid  out  1   one-cycle pulse when digits/blank_mask update
//   seg_error    out  1   sticky: unrecognised non-blank pattern captured
//   anode_error  out  1   sticky: several anodes low for a full stable period
//   stale        out  1   level: no anode change for TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module seven_segment_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  segment,
  output logic [15:0] digits,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        seg_error,
  output logic        anode_error,
  output logic        stale
);

  localparam int STAB_W = $clog2(STABLE_CYCLES);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       blank;
    logic       bad;
  } decode_t;

  // Reverse of the display controller's font table.
  function automatic decode_t decode_seg(input logic [6:0] seg);
    decode_t d;
    d.nib   = 4'h0;
    d.blank = 1'b0;
    d.bad   = 1'b0;
    case (seg)
      7'h40: d.nib = 4'h0;
      7'h79: d.nib = 4'h1;
      7'h24: d.nib = 4'h2;
      7'h30: d.nib = 4'h3;
      7'h19: d.nib = 4'h4;
      7'h12: d.nib = 4'h5;
      7'h02: d.nib = 4'h6;
      7'h78: d.nib = 4'h7;
      7'h00: d.nib = 4'h8;
      7'h10: d.nib = 4'h9;
      7'h08: d.nib = 4'hA;
      7'h03: d.nib = 4'hB;
      7'h46: d.nib = 4'hC;
      7'h21: d.nib = 4'hD;
      7'h06: d.nib = 4'hE;
      7'h0E: d.nib = 4'hF;
      7'h7F: d.blank = 1'b1;
      default: d.bad = 1'b1;
    endcase
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers plus a one-cycle history of the synced bus.
  // The history flops start at the idle bus value so that a bus that is
  // already driven when reset is released is seen as a change.
  // ---------------------------------------------------------------------------
  logic [3:0] an_meta, s_an, an_prev;
  logic [6:0] seg_meta, s_seg, seg_prev;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      an_meta  <= 4'hF;
      s_an     <= 4'hF;
      an_prev  <= 4'hF;
      seg_meta <= 7'h7F;
      s_seg    <= 7'h7F;
      seg_prev <= 7'h7F;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the value from
      // before the edge, so these registers form a real pipeline.
      an_meta  <= anode;
      s_an     <= an_meta;
      an_prev  <= s_an;
      seg_meta <= segment;
      s_seg    <= seg_meta;
      seg_prev <= s_seg;
    end
  end

  logic bus_change, an_change;
  assign an_change  = (s_an != an_prev);
  assign bus_change = an_change || (s_seg != seg_prev);

  // ---------------------------------------------------------------------------
  // Stability counter: number of cycles the synced bus has stayed unchanged.
  // ---------------------------------------------------------------------------
  logic [STAB_W-1:0] stab_cnt;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      stab_cnt <= '0;
    end else if (bus_change) begin
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FSM: one capture per stable period of an active bus.
  // ---------------------------------------------------------------------------
  state_t state, state_next;
  logic   capture_fire;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_next   = state;
    capture_fire = 1'b0;
    case (state)
      IDLE: begin
        if (s_an != 4'hF) state_next = SETTLE;
      end
      SETTLE: begin
        if (s_an == 4'hF) begin
          state_next = IDLE;
        end else if (!bus_change && stab_cnt == STAB_MAX) begin
          // bus_change guards the entry cycle, when the counter still holds
          // the count from the previous period.
          capture_fire = 1'b1;
          state_next   = HELD;
        end
      end
      HELD: begin
        if (bus_change) state_next = (s_an == 4'hF) ? IDLE : SETTLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture datapath
  // ---------------------------------------------------------------------------
  logic [3:0] an_low, cap_bits;
  logic       multi_low;
  decode_t    dec;

  assign an_low    = ~s_an;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_low = |(an_low & (an_low - 4'd1));
  assign cap_bits  = (capture_fire && !multi_low) ? an_low : 4'h0;
  assign dec       = decode_seg(s_seg);

  logic [3:0] shadow_nib [4];
  logic [3:0] shadow_blank;
  logic [3:0] cap_mask;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      // NOTE: the shadow store is only four nibbles. It is reset so that a
      // frame never publishes stale data from before reset.
      for (int i = 0; i < 4; i++) shadow_nib[i] <= 4'h0;
      shadow_blank <= 4'h0;
      cap_mask     <= 4'h0;
      digits       <= 16'h0;
      blank_mask   <= 4'h0;
      frame_valid  <= 1'b0;
      seg_error    <= 1'b0;
      anode_error  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cap_bits[i]) begin
          shadow_nib[i]   <= dec.nib;
          shadow_blank[i] <= dec.blank;
        end
      end

      // On the completion cycle the old shadow is published. A capture that
      // lands in the same cycle starts the next frame's mask.
      if (cap_mask == 4'hF) begin
        digits     <= {shadow_nib[3], shadow_nib[2], shadow_nib[1], shadow_nib[0]};
        blank_mask <= shadow_blank;
        cap_mask   <= cap_bits;
      end else begin
        cap_mask   <= cap_mask | cap_bits;
      end
      frame_valid <= (cap_mask == 4'hF);

      if (|cap_bits && dec.bad)      seg_error   <= 1'b1;
      if (capture_fire && multi_low) anode_error <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall detector: counts cycles since the last anode change.
  // ---------------------------------------------------------------------------
  logic [TO_W-1:0] stale_cnt;

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      stale_cnt <= '0;
    end else if (an_change) begin
      stale_cnt <= '0;
    end else if (stale_cnt != TO_MAX) begin
      stale_cnt <= stale_cnt + 1'b1;
    end
  end

  assign stale = (stale_cnt == TO_MAX);

endmodule

// File: tb/tb_seven_segment_capture.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_capture
//
// Directed scenarios followed by a randomized bus scan. A hold-level reference
// model predicts the published frames and the sticky error flags:
//   - a hold long enough to settle captures its digit;
//   - a short glitch captures nothing;
//   - four distinct digits captured make a frame.
// A negedge monitor compares every frame_valid pulse against the model.
// -----------------------------------------------------------------------------
module tb_seven_segment_capture;

  localparam int STABLE  = 8;
  localparam int TIMEOUT = 64;
  localparam int LONG_MIN  = STABLE + 8;
  localparam int SHORT_MAX = STABLE - 3;

  logic        clk_100MHz = 1'b0;
  logic        rst_n;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic        frame_valid;
  logic        seg_error;
  logic        anode_error;
  logic        stale;

  seven_segment_capture #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (rst_n),
    .anode      (anode),
    .segment    (segment),
    .digits     (digits),
    .blank_mask (blank_mask),
    .frame_valid(frame_valid),
    .seg_error  (seg_error),
    .anode_error(anode_error),
    .stale      (stale)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] bad_tbl [4]  = '{7'h55, 7'h2A, 7'h7E, 7'h01};

  logic [3:0]  m_nib [4];
  logic [3:0]  m_blank;
  logic [3:0]  m_mask;
  logic        m_seg_err;
  logic        m_an_err;
  logic [19:0] exp_q [$];   // {blank_mask, digits}
  logic [3:0]  prev_an;
  logic [6:0]  prev_seg;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_blank   = 4'h0;
    m_mask    = 4'h0;
    m_seg_err = 1'b0;
    m_an_err  = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [3:0] an, input logic [6:0] seg, input int n);
    logic [3:0] low;
    logic [3:0] nib;
    logic       found;
    low = ~an;
    if (n < LONG_MIN || low == 4'h0) return;
    if ($countones(low) > 1) begin
      m_an_err = 1'b1;
      return;
    end
    nib   = 4'h0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg_tbl[k] == seg) begin
        nib   = 4'(k);
        found = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (low[i]) begin
        m_nib[i]   = nib;
        m_blank[i] = (seg == 7'h7F);
        m_mask[i]  = 1'b1;
      end
    end
    if (!found && seg != 7'h7F) m_seg_err = 1'b1;
    if (m_mask == 4'hF) begin
      exp_q.push_back({m_blank, m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
      m_mask = 4'h0;
    end
  endtask

  // Apply one bus value for n cycles, starting at a falling edge.
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    model_apply(an, seg, n);
    anode    = an;
    segment  = seg;
    prev_an  = an;
    prev_seg = seg;
    repeat (n) @(negedge clk_100MHz);
  endtask

  // ---------------------------------------------------------------------------
  // Frame monitor
  // ---------------------------------------------------------------------------
  logic fv_prev = 1'b0;

  always @(negedge clk_100MHz) begin
    logic [19:0] e;
    if (rst_n === 1'b1 && frame_valid === 1'b1) begin
      check("frame_valid_single_cycle", 32'(fv_prev), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("frame_digits", 32'(digits), 32'(e[15:0]));
        check("frame_blank_mask", 32'(blank_mask), 32'(e[19:16]));
        check("frame_seg_error", 32'(seg_error), 32'(m_seg_err));
        check("frame_anode_error", 32'(anode_error), 32'(m_an_err));
      end
    end
    fv_prev = (rst_n === 1'b1) && (frame_valid === 1'b1);
  end

  // Hard bound on the whole run.
  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish within bound");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    prev_an  = 4'hF;
    prev_seg = 7'h7F;
    anode    = 4'hF;
    segment  = 7'h7F;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk_100MHz);

    check("reset_digits", 32'(digits), 32'h0);
    check("reset_blank_mask", 32'(blank_mask), 32'h0);
    check("reset_frame_valid", 32'(frame_valid), 32'h0);
    check("reset_seg_error", 32'(seg_error), 32'h0);
    check("reset_anode_error", 32'(anode_error), 32'h0);
    check("reset_stale", 32'(stale), 32'h0);

    rst_n = 1'b1;
    repeat (2) @(negedge clk_100MHz);

    // Basic scan 0,1,2,3.
    hold(4'b1110, 7'h40, 100);
    hold(4'b1101, 7'h79, 100);
    hold(4'b1011, 7'h24, 100);
    hold(4'b0111, 7'h30, 100);
    check("scan_digits", 32'(digits), 32'h3210);
    check("scan_blank_mask", 32'(blank_mask), 32'h0);
    check("scan_errors", 32'({seg_error, anode_error}), 32'h0);

    // Short glitch to 8 inside a hold of 5.
    hold(4'b1110, 7'h12, 20);
    hold(4'b1110, 7'h00, 5);
    hold(4'b1110, 7'h12, 100);
    hold(4'b1101, 7'h79, 100);
    hold(4'b1011, 7'h24, 100);
    hold(4'b0111, 7'h30, 100);
    check("glitch_digits", 32'(digits), 32'h3215);

    // Blank digit 2.
    hold(4'b1110, 7'h08, 100);
    hold(4'b1101, 7'h03, 100);
    hold(4'b1011, 7'h7F, 100);
    hold(4'b0111, 7'h46, 100);
    check("blank_digits", 32'(digits), 32'hC0BA);
    check("blank_mask", 32'(blank_mask), 32'h4);

    // Two anodes low.
    hold(4'b1100, 7'h40, 100);
    hold(4'hF, 7'h7F, 20);
    check("multi_anode_error", 32'(anode_error), 32'h1);
    check("multi_anode_seg_error", 32'(seg_error), 32'h0);

    // Unknown pattern on digit 1.
    hold(4'b1110, 7'h19, 100);
    hold(4'b1101, 7'h55, 100);
    hold(4'b1011, 7'h02, 100);
    hold(4'b0111, 7'h78, 100);
    check("bad_seg_error", 32'(seg_error), 32'h1);
    check("bad_seg_digits", 32'(digits), 32'h7604);

    // Frozen scan: stale rises after TIMEOUT cycles, mask is kept.
    model_apply(4'b1110, 7'h40, TIMEOUT + 10);
    anode = 4'b1110; segment = 7'h40; prev_an = anode; prev_seg = segment;
    repeat (40) @(negedge clk_100MHz);
    check("stale_early", 32'(stale), 32'h0);
    repeat (TIMEOUT + 10 - 40) @(negedge clk_100MHz);
    check("stale_set", 32'(stale), 32'h1);
    model_apply(4'b1101, 7'h21, 100);
    anode = 4'b1101; segment = 7'h21; prev_an = anode; prev_seg = segment;
    @(negedge clk_100MHz);
    check("stale_held_through_sync", 32'(stale), 32'h1);
    repeat (4) @(negedge clk_100MHz);
    check("stale_cleared", 32'(stale), 32'h0);
    repeat (95) @(negedge clk_100MHz);
    hold(4'b1011, 7'h10, 100);
    hold(4'b0111, 7'h0E, 100);
    check("stale_frame_digits", 32'(digits), 32'hF9D0);

    // Reset in the middle of a partial frame.
    hold(4'b1110, 7'h06, 100);
    hold(4'b1101, 7'h0E, 100);
    anode = 4'b1011; segment = 7'h21;
    repeat (3) @(negedge clk_100MHz);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_digits", 32'(digits), 32'h0);
    check("async_reset_flags",
          32'({blank_mask, frame_valid, seg_error, anode_error, stale}), 32'h0);
    model_reset();
    anode = 4'hF; segment = 7'h7F; prev_an = anode; prev_seg = segment;
    repeat (3) @(negedge clk_100MHz);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    // Digits 0 and 1 from before reset must not count toward this frame.
    hold(4'b1011, 7'h19, 100);
    hold(4'b0111, 7'h12, 100);
    check("post_reset_no_frame", 32'(exp_q.size()), 32'h0);
    check("post_reset_digits", 32'(digits), 32'h0);
    hold(4'b1110, 7'h02, 100);
    hold(4'b1101, 7'h78, 100);
    check("post_reset_frame", 32'(digits), 32'h5476);

    // Randomized scanning.
    for (int h = 0; h < 80; h++) begin
      logic [3:0] an;
      logic [3:0] sel;
      logic [6:0] seg;
      int         r;
      int         n;
      do begin
        r = int'($urandom_range(99));
        if (r < 82) begin
          sel = 4'b0001 << $urandom_range(3);
          an  = ~sel;
        end else if (r < 91) begin
          an  = 4'hF;
        end else begin
          sel = 4'b0011 << $urandom_range(2);
          an  = ~sel;
        end
        r = int'($urandom_range(99));
        if (r < 80)      seg = seg_tbl[$urandom_range(15)];
        else if (r < 90) seg = 7'h7F;
        else             seg = bad_tbl[$urandom_range(3)];
      end while (an == prev_an && seg == prev_seg);
      if ($urandom_range(99) < 30) n = int'($urandom_range(SHORT_MAX, 1));
      else                         n = int'($urandom_range(STABLE + 30, LONG_MIN));
      hold(an, seg, n);
    end
    hold(4'hF, 7'h7F, 30);

    check("random_frames_pending", 32'(exp_q.size()), 32'h0);
    check("random_seg_error", 32'(seg_error), 32'(m_seg_err));
    check("random_anode_error", 32'(anode_error), 32'(m_an_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seven_segment_capture.md
Name: seven_segment_capture

Overview:
- Receive-side monitor for the multiplexed 4-digit seven-segment bus (anode/segment) driven by the display controller.
- Samples the bus, decodes each active digit's segment pattern back to a hex nibble, and publishes a coherent 4-digit word once per complete scan.
- Used as a self-checking observer in benches and as an on-board loopback check. Flags malformed anode or segment patterns and stalled scanning.

Parameters:
- STABLE_CYCLES, 16, number of consecutive identical synchronized samples required before a digit is captured (range 2..65535).
- TIMEOUT_CYCLES, 1048576, cycles without any anode change before stale asserts (range 2..2^24).

Ports:
- clk_100MHz  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- anode  input  4  display digit enables, active-low, one-hot-low when valid; bit 0 = rightmost digit.
- segment  input  7  segment drives, active-low; bit0=a … bit6=g.
- digits  output  16  captured frame; [3:0]=digit 0 … [15:12]=digit 3.
- blank_mask  output  4  per digit, 1 = digit was blank (segment=7'h7F) in the frame.
- frame_valid  output  1  one-cycle pulse when digits/blank_mask update.
- seg_error  output  1  sticky; an unrecognised non-blank pattern was captured.
- anode_error  output  1  sticky; more than one anode low for a full stable period.
- stale  output  1  level; high while no anode change for TIMEOUT_CYCLES.

Behaviour:
- Reset (reset=0, async): digits=0, blank_mask=0, frame_valid=0, seg_error=0, anode_error=0, stale=0. Sync flops are preset to anode=4'hF and segment=7'h7F. Counters, capture mask and shadow registers clear. FSM=IDLE.
- Input sync: anode and segment each pass through 2 flops; all logic uses the synced values (s_an, s_seg).
- Stability counter: clears to 0 when {s_an,s_seg} differs from the previous cycle, else increments and saturates at STABLE_CYCLES-1.
- FSM states:
  - IDLE: s_an=4'hF. Nothing captured. Go to SETTLE when any anode bit is low.
  - SETTLE: waiting for stability. A change restarts the count. All anodes high returns to IDLE. On the cycle the counter reaches STABLE_CYCLES-1, perform a capture and go to HELD.
  - HELD: exactly one capture per stable period. Any change in {s_an,s_seg} goes to SETTLE, or to IDLE if s_an=4'hF.
- Capture:
  - Exactly one anode low: decode s_seg into the shadow nibble for that digit. Set its capture-mask bit and its shadow blank bit.
  - More than one anode low: no capture; set anode_error.
- Decode table (segment -> nibble):
  - Digits: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
  - Letters: 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
  - Blank: 7F -> nibble 0, blank bit=1.
  - Any other pattern -> nibble 0, blank bit=0, seg_error=1.
- Frame completion:
  - When the capture mask becomes 4'hF, on the following edge copy the shadow into digits/blank_mask, pulse frame_valid for 1 cycle, and clear the mask.
  - A capture landing in the completion cycle goes into the next frame.
- Re-capture: capturing an already-masked digit before the frame completes overwrites its shadow value (latest wins). The frame still completes only when all four digits are present.
- Latency: bus change to capture = 2 (sync) + STABLE_CYCLES cycles. Capture of the 4th digit to frame_valid = 1 cycle.
- Stale: a counter clears on any s_an change and saturates at TIMEOUT_CYCLES. stale is high while saturated and clears on the cycle after the next anode change. The capture mask is not cleared by stale.
- Errors: seg_error and anode_error are sticky until reset.
- Reset mid-frame: the partial mask is discarded and outputs return to reset values immediately.

Test Plan:
- Reset release, then scan digit0..3 with patterns 40,79,24,30, each held 100 cycles -> one frame_valid pulse; digits=16'h3210, blank_mask=0, no errors.
- Segment glitch shorter than STABLE_CYCLES (e.g. 7'h00 held 5 cycles inside a 7'h12 hold) -> no capture of 8; the digit captures as 5.
- Digit 2 driven 7'h7F, others 08,03,46 -> digits=16'h0C?b? pattern with blank_mask=4'b0100 and digit2 nibble 0; concretely anode0=08, anode1=03, anode3=46 gives digits=16'hC0BA.
- Two anodes low (4'b1100) held 100 cycles -> anode_error=1, no mask bit set, no frame_valid.
- Pattern 7'h55 on digit1 -> seg_error=1 after capture; the frame still completes with nibble 0 at [7:4].
- Freeze the bus with anode=4'b1110 for TIMEOUT_CYCLES+10 (TIMEOUT_CYCLES=64 in the bench) -> stale=1 at 64 cycles after the last change, cleared after the next anode change. Asserting reset mid-scan clears all outputs asynchronously.
